// File: rtl/divsigned_seq.sv
// divsigned_seq: iterative signed divider, one restoring subtract-and-shift step per cycle.
// Optional macro DIVSIGNED_ZERO_BYPASS_EN: a zero divisor is resolved right after acceptance.
module divsigned_seq #(
    parameter int SIZE = 18
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [SIZE-1:0] dividend_i,
    input  logic [SIZE-1:0] divisor_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [SIZE-1:0] quotient_o,
    output logic [SIZE-1:0] remainder_o,
    output logic            div_by_zero_o
);

    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0]   CNT_INIT = CW'(SIZE - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [SIZE-1:0] ONE      = SIZE'(1);
    localparam logic [SIZE:0]   ONE_W    = (SIZE + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ABS,
        ITER,
        SIGN
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] dividend_q, dividend_d;
    logic [SIZE-1:0] divisor_q, divisor_d;
    logic            negDividend_q, negDividend_d;
    logic            negDivisor_q, negDivisor_d;
    logic            zeroDiv_q, zeroDiv_d;
    logic [SIZE:0]   divMag_q, divMag_d;
    logic [SIZE-1:0] remAcc_q, remAcc_d;
    logic [SIZE-1:0] quotAcc_q, quotAcc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SIZE-1:0] quotient_q, quotient_d;
    logic [SIZE-1:0] remainder_q, remainder_d;
    logic            divByZero_q, divByZero_d;
    logic            valid_q, valid_d;

    logic [SIZE:0]   shifted;
    logic [SIZE:0]   trial;

    // Partial remainder is always below |divisor| <= 2^(SIZE-1), so the top bit of trial is its sign.
    assign shifted = {remAcc_q, quotAcc_q[SIZE-1]};
    assign trial   = shifted + ~divMag_q + ONE_W;

    always_comb begin
        state_d       = state_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        negDividend_d = negDividend_q;
        negDivisor_d  = negDivisor_q;
        zeroDiv_d     = zeroDiv_q;
        divMag_d      = divMag_q;
        remAcc_d      = remAcc_q;
        quotAcc_d     = quotAcc_q;
        count_d       = count_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        divByZero_d   = divByZero_q;
        valid_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dividend_d    = dividend_i;
                    divisor_d     = divisor_i;
                    negDividend_d = dividend_i[SIZE-1];
                    negDivisor_d  = divisor_i[SIZE-1];
                    zeroDiv_d     = (divisor_i == '0);
`ifdef DIVSIGNED_ZERO_BYPASS_EN
                    state_d       = (divisor_i == '0) ? SIGN : ABS;
`else
                    state_d       = ABS;
`endif
                end
            end

            ABS: begin
                quotAcc_d = negDividend_q ? (~dividend_q + ONE) : dividend_q;
                divMag_d  = {1'b0, (negDivisor_q ? (~divisor_q + ONE) : divisor_q)};
                remAcc_d  = '0;
                count_d   = CNT_INIT;
                state_d   = ITER;
            end

            ITER: begin
                remAcc_d  = trial[SIZE] ? shifted[SIZE-1:0] : trial[SIZE-1:0];
                quotAcc_d = {quotAcc_q[SIZE-2:0], ~trial[SIZE]};
                count_d   = count_q - CNT_ONE;
                if (count_q == '0) begin
                    state_d = SIGN;
                end
            end

            SIGN: begin
                // Truncation toward zero: remainder follows the dividend's sign.
                if (zeroDiv_q) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                    divByZero_d = 1'b1;
                end else begin
                    quotient_d  = (negDividend_q ^ negDivisor_q) ? (~quotAcc_q + ONE) : quotAcc_q;
                    remainder_d = negDividend_q ? (~remAcc_q + ONE) : remAcc_q;
                    divByZero_d = 1'b0;
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            dividend_q    <= '0;
            divisor_q     <= '0;
            negDividend_q <= 1'b0;
            negDivisor_q  <= 1'b0;
            zeroDiv_q     <= 1'b0;
            divMag_q      <= '0;
            remAcc_q      <= '0;
            quotAcc_q     <= '0;
            count_q       <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            divByZero_q   <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            negDividend_q <= negDividend_d;
            negDivisor_q  <= negDivisor_d;
            zeroDiv_q     <= zeroDiv_d;
            divMag_q      <= divMag_d;
            remAcc_q      <= remAcc_d;
            quotAcc_q     <= quotAcc_d;
            count_q       <= count_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            divByZero_q   <= divByZero_d;
            valid_q       <= valid_d;
        end
    end

    assign ready_o       = (state_q == IDLE);
    assign valid_o       = valid_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = divByZero_q;

endmodule
